// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks base..base+length-1 on a BRAM with a 1-cycle registered read and streams the words out.
// Latency: out_valid rises two edges after the accepting start edge; sustains one word per clock.
// Backpressure: out_ready low holds the head word; reads stop once FIFO words plus the in-flight read reach 2.
// Optional abort input: define BRAM_STREAM_READER_ABORT_EN.

// Two-entry skid FIFO that catches BRAM read data while the stream is stalled.
module bram_stream_reader_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;

  // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Storage and pointers; flush drops everything, including a push on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_dat_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_i) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rptr_q];
  assign cnt_o      = cnt_q;

  // The issue rule upstream must keep the FIFO from overflowing.
  assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && (cnt_q == 2'd2)));

  // The stream never pops an empty FIFO.
  assert property (@(posedge clk) disable iff (rst)
    !(pop_i && !flush_i && (cnt_q == 2'd0)));

endmodule

module bram_stream_reader #(
  parameter int ABITS = 12,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [ABITS:0]   length,
`ifdef BRAM_STREAM_READER_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [ABITS-1:0] mem_addr,
  input  logic [DBITS-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ABITS:0]   LEN_ONE  = (ABITS+1)'(1);
  localparam logic [ABITS-1:0] ADDR_ONE = ABITS'(1);

  state_t           state_q;
  logic [ABITS-1:0] addr_q;
  logic [ABITS:0]   rem_q;
  logic [ABITS:0]   left_q;
  logic             pend_q;
  logic             done_q;

  logic [1:0]       fcnt;
  logic [DBITS-1:0] head_dat;
  logic             pop;
  logic             issue;
  logic             abort_w;
  logic [2:0]       occ;

  // Abort only has an effect while a transfer is running.
`ifdef BRAM_STREAM_READER_ABORT_EN
  assign abort_w = (state_q == RUN) && abort;
`else
  assign abort_w = 1'b0;
`endif

  assign pop = out_valid && out_ready;

  // Words held or in flight once this edge's pop has left; a new read may only start below 2.
  assign occ = {1'b0, fcnt} + {2'b00, pend_q} - {2'b00, pop};

  // Read issue: addresses remain and the FIFO can absorb the data two edges from now.
  assign issue = (state_q == RUN) && (rem_q != '0) && (occ < 3'd2) && !abort_w;

  bram_stream_reader_fifo #(
    .W(DBITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (abort_w),
    .push_i     (pend_q),
    .push_dat_i (mem_rdata),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .cnt_o      (fcnt)
  );

  // Transfer control: launch, address walk, pop accounting, completion and abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      left_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= issue;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state_q <= RUN;
              addr_q  <= base_addr;
              rem_q   <= length;
              left_q  <= length;
            end else begin
              // Empty transfer completes immediately without entering RUN.
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_w) begin
            state_q <= IDLE;
            rem_q   <= '0;
            left_q  <= '0;
          end else begin
            if (issue) begin
              addr_q <= addr_q + ADDR_ONE;
              rem_q  <= rem_q - LEN_ONE;
            end
            if (pop) begin
              left_q <= left_q - LEN_ONE;
              if (left_q == LEN_ONE) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign out_valid = (fcnt != 2'd0);
  assign out_data  = head_dat;
  assign out_last  = out_valid && (left_q == LEN_ONE);

  // A stalled word stays put until it is taken or the transfer is aborted.
  assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !abort_w) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, queue of expected words, negedge monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Abort scenarios are included when BRAM_STREAM_READER_ABORT_EN is defined.
module tb_bram_stream_reader;

  localparam int ABITS = 12;
  localparam int DBITS = 8;
  localparam int DEPTH = 1 << ABITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [ABITS-1:0] base_addr = '0;
  logic [ABITS:0]   length = '0;
  logic             abort_s = 1'b0;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             done;
  logic [ABITS-1:0] mem_addr;
  logic [DBITS-1:0] mem_rdata;
  logic             out_valid;
  logic [DBITS-1:0] out_data;
  logic             out_last;

  bram_stream_reader #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
`ifdef BRAM_STREAM_READER_ABORT_EN
    .abort     (abort_s),
`endif
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // BRAM model: registered read, no enable.
  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected words {last,data}, predicted busy/done for the next cycle.
  logic [DBITS:0] exp_q[$];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit stall_q = 1'b0;
  bit abort_seen = 1'b0;
  logic [DBITS-1:0] stall_dat;
  logic stall_last;
  int acc_issued = 0, acc_seen = 0;
  int zl_issued = 0, zl_seen = 0;
  int pop_cnt = 0;

  // Monitor: compare present outputs to predictions, then predict the next edge.
  always @(negedge clk) begin
    logic [DBITS:0] e;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      stall_q = 1'b0;
      abort_seen = 1'b0;
      acc_seen = acc_issued;
      zl_seen = zl_issued;
    end else begin
      check("busy", 32'(busy), 32'(m_busy));
      if (done || m_done) check("done", 32'(done), 32'(m_done));
      if (stall_q) begin
        check("stall_vld", 32'(out_valid), 32'd1);
        check("stall_dat", 32'(out_data), 32'(stall_dat));
        check("stall_last", 32'(out_last), 32'(stall_last));
      end
      if (abort_seen) check("abort_vld", 32'(out_valid), 32'd0);
      m_done = 1'b0;
      abort_seen = 1'b0;
      if (abort_s && m_busy) begin
        m_busy = 1'b0;
        abort_seen = 1'b1;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_vld", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          pop_cnt++;
          check("data", 32'(out_data), 32'(e[DBITS-1:0]));
          check("last", 32'(out_last), 32'(e[DBITS]));
          if (e[DBITS]) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
      if (acc_issued != acc_seen) begin
        m_busy = 1'b1;
        acc_seen = acc_issued;
      end
      if (zl_issued != zl_seen) begin
        m_done = 1'b1;
        zl_seen = zl_issued;
      end
      stall_q = out_valid && !out_ready && !abort_seen;
      stall_dat = out_data;
      stall_last = out_last;
    end
  end

  // Ready patterns: 0 always ready, 1 fixed toggle pattern, 2 random.
  int rmode = 0;
  int pidx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = pat[pidx % 6];
        pidx++;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Drive a start for one edge; queue the expected words when the model is idle.
  task automatic do_start(input logic [ABITS-1:0] b, input logic [ABITS:0] l);
    logic [ABITS-1:0] a;
    start = 1'b1;
    base_addr = b;
    length = l;
    if (!m_busy) begin
      if (l == '0) begin
        zl_issued++;
      end else begin
        a = b;
        for (int i = 0; i < int'(l); i++) begin
          exp_q.push_back({(i == int'(l) - 1), mem[a]});
          a = a + ABITS'(1);
        end
        acc_issued++;
      end
    end
    tick();
    start = 1'b0;
    base_addr = ABITS'($urandom);
    length = (ABITS+1)'($urandom);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) check("timeout_busy", 32'(m_busy), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = DBITS'(a);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Basic transfer with latency and back-to-back data.
    rmode = 0;
    do_start(12'h010, 13'd4);
    check("lat_vld_e0", 32'(out_valid), 32'd0);
    check("addr_e0", 32'(mem_addr), 32'h010);
    tick();
    check("lat_vld_e1", 32'(out_valid), 32'd0);
    check("addr_e1", 32'(mem_addr), 32'h011);
    tick();
    check("lat_vld_e2", 32'(out_valid), 32'd1);
    check("first_data", 32'(out_data), 32'h10);
    tick();
    check("vld_e3", 32'(out_valid), 32'd1);
    tick();
    check("vld_e4", 32'(out_valid), 32'd1);
    check("last_e4", 32'(out_last), 32'd0);
    tick();
    check("vld_e5", 32'(out_valid), 32'd1);
    check("last_e5", 32'(out_last), 32'd1);
    wait_idle(50);

    for (int a = 0; a < DEPTH; a++) mem[a] = DBITS'($urandom);

    // Address wrap at the top of the BRAM.
    do_start(12'hFFE, 13'd4);
    check("wrap_a0", 32'(mem_addr), 32'hFFE);
    tick();
    check("wrap_a1", 32'(mem_addr), 32'hFFF);
    tick();
    check("wrap_a2", 32'(mem_addr), 32'h000);
    tick();
    check("wrap_a3", 32'(mem_addr), 32'h001);
    wait_idle(50);

    // Toggling backpressure.
    rmode = 1;
    pidx = 0;
    do_start(ABITS'($urandom), 13'd8);
    wait_idle(100);

    // Zero length.
    rmode = 0;
    do_start(ABITS'($urandom), 13'd0);
    check("zl_busy", 32'(busy), 32'd0);
    check("zl_vld", 32'(out_valid), 32'd0);
    check("zl_done", 32'(done), 32'd1);
    tick();
    check("zl_done_off", 32'(done), 32'd0);
    check("zl_vld2", 32'(out_valid), 32'd0);

    // Start while busy is ignored.
    rmode = 1;
    do_start(12'h200, 13'd6);
    tick();
    tick();
    do_start(12'h300, 13'd5);
    wait_idle(100);

    // Start accepted in the done cycle.
    rmode = 0;
    do_start(ABITS'($urandom), 13'd3);
    wait_idle(50);
    check("b2b_done", 32'(done), 32'd1);
    do_start(ABITS'($urandom), 13'd5);
    wait_idle(50);

    // Random transfers.
    for (int t = 0; t < 25; t++) begin
      rmode = $urandom_range(0, 2);
      do_start(ABITS'($urandom), (ABITS+1)'($urandom_range(0, 20)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        do_start(ABITS'($urandom), (ABITS+1)'($urandom_range(1, 20)));
      end
      wait_idle(200);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Full address space from a random base.
    rmode = 2;
    do_start(ABITS'($urandom), 13'h1000);
    wait_idle(20000);

    // Asynchronous reset mid-transfer.
    rmode = 0;
    do_start(ABITS'($urandom), 13'd20);
    repeat (5) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_last", 32'(out_last), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();

`ifdef BRAM_STREAM_READER_ABORT_EN
    for (int a = 0; a < DEPTH; a++) mem[a] = DBITS'(a);
    begin
      int p0;
      int n;
      rmode = 0;
      do_start(12'h050, 13'd10);
      p0 = pop_cnt;
      n = 0;
      while (pop_cnt - p0 < 3 && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) check("timeout_pops", 32'(pop_cnt - p0), 32'd3);
      abort_s = 1'b1;
      exp_q.delete();
      tick();
      abort_s = 1'b0;
      check("abort_vld_now", 32'(out_valid), 32'd0);
      check("abort_busy_now", 32'(busy), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      do_start(12'h100, 13'd2);
      wait_idle(50);
      tick();
      abort_s = 1'b1;
      tick();
      abort_s = 1'b0;
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_idle_done", 32'(done), 32'd0);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side initiator for a generic dual-port BRAM port. The BRAM has no read enable and a 1-cycle registered read.
- Given a base address and length, it walks consecutive addresses and presents the words on a valid/ready stream with full backpressure.
- Used to drain line buffers and waveform tables into downstream pixel pipelines at one word per clock.

Parameters:
ABITS, 12, BRAM address width
DBITS, 8, BRAM data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  launch request; sampled only when busy=0
base_addr  in  ABITS  first address, latched on start
length  in  ABITS+1  word count, 0..2^ABITS, latched on start
busy  out  1  transfer in progress
done  out  1  one-cycle pulse on transfer completion
mem_addr  out  ABITS  address to BRAM port; BRAM write enable is tied low
mem_rdata  in  DBITS  BRAM registered read data
out_valid  out  1  stream word available
out_ready  in  1  downstream accepts
out_data  out  DBITS  stream word
out_last  out  1  marks final word of transfer

Behaviour:
- Reset (async, active-high): busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0, FIFO empty, pend=0, all counters 0.
- States are IDLE and RUN.
- IDLE to RUN: on an edge where start=1 and length!=0.
  - Latch mem_addr<=base_addr, issue counter rem<=length, pop counter left<=length.
  - busy=1 from that edge.
- Zero length: start=1 with length=0 stays in IDLE. done pulses for one cycle after that edge; busy stays 0; out_valid never rises.
- start while busy=1 is ignored.
- Issue rule (RUN): issue=1 iff rem!=0 and (fcnt + pend − pop) < 2.
  - fcnt is FIFO occupancy (0..2); pop = out_valid & out_ready.
  - On issue, the current mem_addr is the read address. At the edge: mem_addr<=mem_addr+1 (wraps modulo 2^ABITS), rem<=rem−1, pend<=1. Otherwise pend<=0.
- Capture: when pend=1, mem_rdata is pushed into a 2-entry FIFO at the next edge.
- Push and pop in the same cycle keep fcnt unchanged.
- FIFO can never overflow because of the issue rule. Pushing when fcnt=2 and no pop is a verification assertion failure.
- out_valid = (fcnt!=0). out_data and out_last come from the FIFO head. out_last=1 iff left==1.
- Each pop decrements left.
- Latency: start edge E0, first issue in cycle E0..E1, mem_rdata valid after E1, captured at E2, out_valid=1 after E2.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure:
  - out_ready=0 holds out_data/out_last stable while out_valid=1.
  - Issue stops at occupancy 2. mem_addr holds while no issue.
- Completion: on the edge popping the word with out_last=1, go RUN to IDLE, busy<=0, done<=1 for exactly one cycle.
- start in the cycle where done=1 is accepted (busy=0).
- length=2^ABITS reads every address exactly once, wrapping through 2^ABITS−1 to 0 from any base.
- Reset mid-transfer aborts immediately to reset values. No done pulse.

Optional Feature:
- Macro: BRAM_STREAM_READER_ABORT_EN.
- Defined: adds port abort (in, 1). abort=1 in RUN at an edge does all of the following:
  - Empties the FIFO and clears pend, rem and left.
  - Enters IDLE, with busy=0 and out_valid=0 after the edge.
  - Produces no done pulse.
  - abort has priority over a simultaneous pop. abort in IDLE is ignored. start is accepted the cycle after an abort.
- Undefined: no abort port; transfers always run to completion or reset.

Test Plan:
- BRAM preloaded mem[a]=a[7:0], base=0x010, length=4, out_ready=1 -> out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles. out_valid first high 2 cycles after start edge. out_last only on 0x13. done one cycle after last pop.
- base=0xFFE, length=4 -> mem_addr sequence 0xFFE,0xFFF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
- length=8, out_ready toggling 1,0,0,1,0,1... -> all 8 words in order, no duplicates or loss. out_data stable while stalled. FIFO occupancy never exceeds 2.
- length=0 -> done pulses one cycle after start; busy and out_valid stay 0.
- start asserted while busy with different base -> ignored; original 6-word transfer completes unchanged. Reset asserted mid-transfer -> all outputs 0 immediately (async).
- ABORT_EN build: abort after 3 of 10 words popped -> out_valid=0 next cycle, no done. New start base=0x100, length=2 returns 0x00,0x01 correctly.
